// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state encoding and WAIT_CYCLES limits for sram_ctrl.
//   S_IDLE / S_SETUP / S_ACCESS / S_HOLD  controller phases
//   WAIT_MIN / WAIT_MAX                   legal ACCESS length in clk cycles
//   wait_load()                           clamped counter reload value (WAIT_CYCLES-1)
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // An out-of-range WAIT_CYCLES is pulled into range so the 4-bit counter can never wrap.
    function automatic logic [3:0] wait_load(input int w);
        int c;
        c = (w < WAIT_MIN) ? WAIT_MIN : ((w > WAIT_MAX) ? WAIT_MAX : w);
        return 4'(c - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_arb.sv
// sram_ctrl_arb: two-port arbiter producing a one-hot grant for sram_ctrl.
//   clk, rst_n    clock and synchronous active-low reset
//   req0, req1    port requests
//   grant_en      arbitration window (controller idle); grant is zero outside it
//   grant[1:0]    one-hot grant, bit 0 = port 0, bit 1 = port 1
// Build option SRAM_CTRL_RR_EN: round-robin on ties; otherwise port 0 has fixed priority.
module sram_ctrl_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic [1:0] grant_raw;

`ifdef SRAM_CTRL_RR_EN
    // last_q = 1 means port 1 was served last, so port 0 wins the next tie.
    logic last_q;

    assign grant_raw = (req0 && req1) ? (last_q ? 2'b01 : 2'b10) : {req1, req0};

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else if (|grant) last_q <= grant[1];
    end
`else
    logic unused_ok;

    assign grant_raw = req0 ? 2'b01 : {req1, 1'b0};
    assign unused_ok = ^{clk, rst_n};
`endif

    assign grant = grant_en ? grant_raw : 2'b00;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: two-port request/done controller for an asynchronous byte-wide SRAM.
//   clk, rst_n                  clock and synchronous active-low reset
//   req0/1, we0/1, addr0/1,     per-port request, write flag, address, write data
//   wdata0/1
//   done0/1                     one-cycle completion pulse in the HOLD cycle
//   rdata                       last read data, held until the next read completes
//   busy                        controller not idle
//   sram_addr, sram_dq          SRAM address pins and bidirectional data pins
//   sram_ce_n/we_n/oe_n         registered active-low strobes
//   sram_ub_n, sram_lb_n        byte lanes, low byte only
// Build option SRAM_CTRL_RR_EN selects round-robin arbitration (see sram_ctrl_arb).
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam logic [3:0] LOAD = wait_load(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_n_q, we_n_q, oe_n_q, dq_oe_q, done0_q, done1_q;
    logic [1:0]        grant;

    sram_ctrl_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .grant_en (state_q == S_IDLE),
        .grant    (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    state_d = S_SETUP;
                    port_d  = grant[1];
                    we_d    = grant[1] ? we1 : we0;
                    addr_d  = grant[1] ? addr1 : addr0;
                    wdata_d = grant[1] ? wdata1 : wdata0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = LOAD;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) state_d = S_HOLD;
                else cnt_d = cnt_q - 4'd1;
            end
            S_HOLD: state_d = S_IDLE;
        endcase
        // Read data is sampled at the edge closing the last ACCESS cycle, while OE is still low.
        rdata_d = (state_q == S_ACCESS && cnt_q == 4'd0 && !we_q) ? sram_dq : rdata_q;
    end

    // Strobes are registered from the next state so the SRAM pins never see decode glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= state_d == S_IDLE;
            we_n_q  <= !(we_d && state_d == S_ACCESS);
            oe_n_q  <= !(!we_d && (state_d == S_SETUP || state_d == S_ACCESS));
            dq_oe_q <= we_d && state_d != S_IDLE;
            done0_q <= state_d == S_HOLD && !port_d;
            done1_q <= state_d == S_HOLD && port_d;
        end
    end

    assign sram_dq   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_ub_n = 1'b1;
    assign sram_lb_n = 1'b0;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign busy      = state_q != S_IDLE;

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Two-port request/done controller that sequences all accesses to the board's external asynchronous byte-wide SRAM. It sits between the design logic and the SRAM pins, arbitrating two requesters (port 0, port 1) and generating CE/WE/OE timing with a programmable wait count. It also drives the bidirectional data bus and captures read data. It replaces direct pin-level WE/OE control from the top level.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 8, data width (low byte lane)
- WAIT_CYCLES, 2, length of the ACCESS phase in clk cycles; legal range 1..15

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse for that port
- rdata  out  DATA_W  read data; holds its value until the next read completes
- busy  out  1  high whenever the FSM is not IDLE
- sram_addr  out  ADDR_W  SRAM address pins
- sram_dq  inout  DATA_W  SRAM data pins
- sram_ce_n, sram_we_n, sram_oe_n  out  1  active-low strobes
- sram_ub_n, sram_lb_n  out  1  constant 1 and 0 (low byte only)

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any req is high, grant one port. The grant latches that port's we/addr/wdata into internal registers and moves to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): ce_n=0; sram_addr driven.
  - Read: oe_n=0.
  - Write: dq driven, we_n=1, oe_n=1.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - Write: we_n=0.
  - Read: oe_n=0. rdata is loaded from sram_dq at the edge that ends the last ACCESS cycle.
- HOLD (1 cycle): we_n=1, oe_n=1, ce_n=0, address held. For a write, dq stays driven. done for the granted port is high. Next state is always IDLE.
- sram_dq is driven only in SETUP, ACCESS and HOLD of a write. Otherwise it is high-Z.
- Handshake:
  - The requester holds req high until it sees done.
  - The requester must drop req at the same edge where done is sampled high. Registered logic does this naturally.
  - req still high in the cycle after done counts as a new request.
  - req/addr/data changes after the grant do not affect the current access.
- Arbitration when both ports request in IDLE: see Configuration.
- Reset (rst_n=0 at an edge, in any state, including mid-access):
  - FSM goes to IDLE and any in-flight access is abandoned without a done pulse.
  - Outputs: ce_n=we_n=oe_n=1, dq high-Z, sram_addr=0, rdata=0, done0=done1=0, busy=0.
  - Arbiter pointer is set to "port 1 last served".

## Timing
- Request sampled high in IDLE at cycle t:
  - SETUP: cycle t+1.
  - ACCESS: cycles t+2 .. t+1+WAIT_CYCLES.
  - HOLD with done=1 and new rdata valid: cycle t+2+WAIT_CYCLES.
  - IDLE: cycle t+3+WAIT_CYCLES.
- Access period is WAIT_CYCLES+3 cycles. The earliest next grant is in the IDLE cycle.
- The address is stable from SETUP through HOLD. WE is low only while the address and data are stable, one cycle of margin on each side.
- The ACCESS counter reloads WAIT_CYCLES-1 on entry to ACCESS and leaves ACCESS at 0. It is 4 bits wide.

## Configuration
- SRAM_CTRL_RR_EN defined: round-robin.
  - On simultaneous requests, grant the port not served last.
  - The pointer updates on every grant.
  - A single requester is always granted.
- SRAM_CTRL_RR_EN undefined: fixed priority. Port 0 always wins a tie, and there is no pointer register.

## Structure
- Shared package/include sram_ctrl_pkg:
  - state encoding constants S_IDLE, S_SETUP, S_ACCESS, S_HOLD.
  - WAIT_CYCLES legal-range limits.
- One sub-module, sram_ctrl_arb:
  - inputs req0/req1 and a grant-enable strobe.
  - outputs a one-hot grant.
  - contains the round-robin pointer under SRAM_CTRL_RR_EN.
- The FSM, counter and data path stay in sram_ctrl.

## Test plan
- Reset, then idle: all strobes 1, dq high-Z, busy 0, rdata 0, no done pulses over 20 cycles.
- Port 0 write addr 0x00005, data 0xA5, WAIT_CYCLES=2: we_n low for exactly 2 cycles, dq=0xA5 from SETUP through HOLD, done0 at t+4. Then a port 1 read of 0x00005: rdata=0xA5 with done1.
- Both ports request in the same cycle, repeated 4 times. With SRAM_CTRL_RR_EN the grants go 0,1,0,1. Without it, port 0 gets every grant while it keeps requesting.
- rst_n asserted in the second ACCESS cycle of a write: the next cycle has we_n=1, ce_n=1, dq high-Z, state IDLE, and no done pulse. A later read of that address returns the model's prior value or X, as the bench's SRAM model decides.
- WAIT_CYCLES=1 and WAIT_CYCLES=15: done arrives exactly 3 and 17 cycles after the grant cycle. The bench's SRAM model checks setup/hold against the strobes.
- req held high one cycle too long after done: a second identical access executes. This confirms the stated handshake rule.
